// File: rtl/present_pkg.sv
// present_pkg
// Shared PRESENT-80 definitions used by both the encryptor and the decryptor.
// Contents:
//   BLOCK_W / KEY_W / CTR_W   datapath widths (64-bit block, 80-bit key, 5-bit round counter)
//   SBOX_TABLE / INV_SBOX_TABLE  4-bit S-box and its inverse, packed one nibble per input value
//   fsm_state_t               control states of the iterative cores
//   sbox_layer / inv_sbox_layer, player / inv_player,
//   key_update / inv_key_update   round building blocks
package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int CTR_W   = 5;

    // Entry for input value x lives in bits [4x+3:4x].
    localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_WHITEN,
        ST_DECRYPT,
        ST_DONE
    } fsm_state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays put.
    function automatic logic [BLOCK_W-1:0] player(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_player(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
        y[63] = x[63];
        return y;
    endfunction

    // Rotate left by 61 is the same as rotate right by 19.
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [CTR_W-1:0] ctr);
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ ctr;
        return t;
    endfunction

    // Undo key_update step by step in reverse order; rotate right 61 == rotate left 19.
    function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                        input logic [CTR_W-1:0] ctr);
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ ctr;
        t[79:76]   = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_dec_round.sv
// present_dec_round
// One combinational PRESENT-80 decryption round.
// Ports:
//   i_state       current 64-bit cipher state
//   i_key         round key K(ctr+1) currently held in the key register
//   i_ctr         round counter of the round being undone
//   o_next_state  state after inverse permutation, inverse S-box layer and key add
//   o_prev_key    round key K(ctr), also the key mixed into o_next_state
module present_dec_round
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [KEY_W-1:0]   i_key,
    input  logic [CTR_W-1:0]   i_ctr,
    output logic [BLOCK_W-1:0] o_next_state,
    output logic [KEY_W-1:0]   o_prev_key
);

    logic [KEY_W-1:0] w_prev_key;

    // Step the key schedule backwards first; the recovered key is the one
    // the encryptor added before this round's substitution.
    always_comb begin
        w_prev_key   = inv_key_update(i_key, i_ctr);
        o_prev_key   = w_prev_key;
        o_next_state = inv_sbox_layer(inv_player(i_state)) ^ w_prev_key[79:16];
    end

endmodule

// File: rtl/present80_decrypt.sv
// present80_decrypt
// Iterative PRESENT-80 block decryptor, one round per clock.
// The last round key is not supplied; it is derived by running the key
// schedule forward from the master key, then the schedule is unwound while
// the rounds are undone.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   cipher_text  64-bit ciphertext, captured on the accepted start
//   master_key   80-bit master key, captured on the accepted start
//   out          64-bit plaintext, valid while done is high
//   done         registered completion flag, held until start goes low
module present80_decrypt
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] cipher_text,
    input  logic [KEY_W-1:0]   master_key,
    output logic [BLOCK_W-1:0] out,
    output logic               done
);

    localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(ROUNDS);

    fsm_state_t         r_fsm;
    logic [BLOCK_W-1:0] r_state;
    logic [KEY_W-1:0]   r_key;
    logic [CTR_W-1:0]   r_ctr;
    logic [BLOCK_W-1:0] r_out;
    logic               r_done;

    logic [BLOCK_W-1:0] w_next_state;
    logic [KEY_W-1:0]   w_prev_key;

    present_dec_round u_round (
        .i_state      (r_state),
        .i_key        (r_key),
        .i_ctr        (r_ctr),
        .o_next_state (w_next_state),
        .o_prev_key   (w_prev_key)
    );

    // Control FSM plus all datapath registers. The counter climbs 1..ROUNDS
    // during key expansion and falls ROUNDS..1 during decryption; it is held
    // at its end value rather than stepped past it so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_ctr   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= cipher_text;
                        r_key   <= master_key;
                        r_ctr   <= CTR_W'(1);
                        r_fsm   <= ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    r_key <= key_update(r_key, r_ctr);
                    if (r_ctr == LAST_CTR) begin
                        r_fsm <= ST_WHITEN;
                    end else begin
                        r_ctr <= r_ctr + CTR_W'(1);
                    end
                end
                ST_WHITEN: begin
                    r_state <= r_state ^ r_key[79:16];
                    r_ctr   <= LAST_CTR;
                    r_fsm   <= ST_DECRYPT;
                end
                ST_DECRYPT: begin
                    r_state <= w_next_state;
                    r_key   <= w_prev_key;
                    if (r_ctr == CTR_W'(1)) begin
                        r_out  <= w_next_state;
                        r_done <= 1'b1;
                        r_fsm  <= ST_DONE;
                    end else begin
                        r_ctr <= r_ctr - CTR_W'(1);
                    end
                end
                ST_DONE: begin
                    // Requiring start low here stops a held start from retriggering.
                    if (!start) begin
                        r_done <= 1'b0;
                        r_fsm  <= ST_IDLE;
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign done = r_done;

endmodule

// File: tb/tb_present80_decrypt.sv
// tb_present80_decrypt
// Directed bench for present80_decrypt: published PRESENT-80 vectors, latency,
// mid-operation reset, held start, ignored input changes while busy, and a
// round trip through an independent encryption model.
module tb_present80_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] cipher_text;
    logic [79:0] master_key;
    logic [63:0] out;
    logic        done;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [79:0] KEY0 = 80'h0;
    localparam logic [79:0] KEYF = 80'hFFFFFFFFFFFFFFFFFFFF;

    always #5 clk = ~clk;

    present80_decrypt dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cipher_text (cipher_text),
        .master_key  (master_key),
        .out         (out),
        .done        (done)
    );

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [79:0] observed,
                               input logic [79:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents a request on a falling edge; the next rising edge accepts it.
    // Returns on the falling edge right after the accepting edge.
    task automatic applyStimulus(input logic [63:0] ct, input logic [79:0] key,
                                 input bit holdStart);
        @(negedge clk);
        cipher_text = ct;
        master_key  = key;
        start       = 1'b1;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
    endtask

    // Counts rising edges until done is seen, bounded so a dead DUT cannot hang.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done) break;
        end
    endtask

    task automatic runVector(input string tag, input logic [63:0] ct,
                             input logic [79:0] key, input logic [63:0] expected);
        int n;
        applyStimulus(ct, key, 1'b0);
        waitDone(n);
        checkOutput({tag, " latency"}, 80'(n), 80'd63);
        checkOutput({tag, " out"}, 80'(out), 80'(expected));
    endtask

    function automatic logic [3:0] sboxModel(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    // Reference PRESENT-80 encryption, written in the forward direction only.
    function automatic logic [63:0] encModel(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sboxModel(s[4*n +: 4]);
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sboxModel(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    initial begin
        int  n;
        bit  stayed;
        logic [63:0] pt;
        logic [79:0] key;

        rst = 1'b1;
        start = 1'b0;
        cipher_text = '0;
        master_key = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset out", 80'(out), 80'h0);
        checkOutput("reset done", 80'(done), 80'h0);
        rst = 1'b0;

        // Published test vectors, decrypted
        runVector("vec1", 64'h5579C1387B228445, KEY0, 64'h0000000000000000);
        runVector("vec2", 64'hE72C46C0F5945049, KEYF, 64'h0000000000000000);
        runVector("vec3", 64'hA112FFC72F68417B, KEY0, 64'hFFFFFFFFFFFFFFFF);
        runVector("vec4", 64'h3333DCD3213210D2, KEYF, 64'hFFFFFFFFFFFFFFFF);

        // Reset part-way through: out from vec4 is all ones, so a clear is visible
        applyStimulus(64'h5579C1387B228445, KEY0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset done", 80'(done), 80'h0);
        checkOutput("midreset out", 80'(out), 80'h0);
        rst = 1'b0;
        stayed = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (done) stayed = 1'b0;
        end
        checkOutput("midreset idle", 80'(stayed), 80'h1);
        runVector("restart vec1", 64'h5579C1387B228445, KEY0, 64'h0000000000000000);

        // Start held high: one operation only, done held
        applyStimulus(64'hA112FFC72F68417B, KEY0, 1'b1);
        waitDone(n);
        checkOutput("held latency", 80'(n), 80'd63);
        checkOutput("held out", 80'(out), 80'hFFFFFFFFFFFFFFFF);
        stayed = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (!done || out !== 64'hFFFFFFFFFFFFFFFF) stayed = 1'b0;
        end
        checkOutput("held stable", 80'(stayed), 80'h1);
        start = 1'b0;
        @(negedge clk);
        checkOutput("release done", 80'(done), 80'h0);
        checkOutput("release out kept", 80'(out), 80'hFFFFFFFFFFFFFFFF);
        cipher_text = 64'h5579C1387B228445;
        master_key  = KEY0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(n);
        checkOutput("second latency", 80'(n), 80'd63);
        checkOutput("second out", 80'(out), 80'h0);

        // Input changes while busy must be ignored
        applyStimulus(64'hE72C46C0F5945049, KEYF, 1'b0);
        repeat (10) @(negedge clk);
        cipher_text = 64'hA112FFC72F68417B;
        master_key  = KEY0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(n);
        checkOutput("busy latency", 80'(n + 11), 80'd63);
        checkOutput("busy out", 80'(out), 80'h0);

        // Round trip through the reference encryptor
        for (int v = 0; v < 100; v++) begin
            pt  = {$urandom(), $urandom()};
            key = {16'($urandom()), $urandom(), $urandom()};
            applyStimulus(encModel(pt, key), key, 1'b0);
            waitDone(n);
            checkOutput($sformatf("roundtrip %0d", v), 80'(out), 80'(pt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
